// File: rtl/dal_pkg.sv
// dal_pkg: shared types and defaults for the centre-collection pipeline stage
package dal_pkg;

    localparam int DAL_WIDTH     = 16;
    localparam int DAL_N_INVALID = 4096;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } cc_state_t;

endpackage

// File: rtl/mw_fifo.sv
// mw_fifo: multi-write, single-read synchronous FIFO with occupancy count
module mw_fifo #(
    parameter int DW    = 32,
    parameter int LANES = 2,
    parameter int DEPTH = 16
) (
    input  logic                             CLK_i,
    input  logic                             RST_ni,
    input  logic                             clr_i,
    input  logic [$clog2(DEPTH):0]           wr_num_i,
    input  logic [LANES-1:0][DW-1:0]         wr_data_i,
    input  logic                             rd_en_i,
    output logic [DW-1:0]                    rd_data_o,
    output logic [$clog2(DEPTH):0]           count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;

    // Write the first wr_num_i packed words at consecutive slots; the pointer wraps by width.
    always_ff @(posedge CLK_i)
        for (int k = 0; k < LANES; k++)
            if (CW'(k) < wr_num_i)
                mem[wptr_q + AW'(k)] <= wr_data_i[k];

    // Pointers and occupancy; clr_i empties the FIFO without touching storage.
    always_ff @(posedge CLK_i or negedge RST_ni)
        if (!RST_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + wr_num_i[AW-1:0];
            rptr_q  <= rptr_q + AW'(rd_en_i);
            count_q <= count_q + wr_num_i - CW'(rd_en_i);
        end

    assign rd_data_o = mem[rptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/center_collect.sv
// center_collect: gathers valid per-lane centre ids into a FIFO and drains them with a last marker.
// Optional macro CENTER_COLLECT_DEDUP_EN discards ids repeating the last pushed or an earlier same-cycle id.
module center_collect
    import dal_pkg::*;
#(
    parameter int WIDTH         = DAL_WIDTH,
    parameter int PARALLEL_SIZE = 2,
    parameter int N_INVALID     = DAL_N_INVALID,
    parameter int DEPTH         = 16
) (
    input  logic                                CLK_i,
    input  logic                                RST_ni,
    input  logic [2:0]                          stage_i,
    input  logic                                finished_i,
    input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0] id_i,
    input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0] dnorm_i,
    output logic                                stall_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [WIDTH-1:0]                    out_id_o,
    output logic [WIDTH-1:0]                    out_dnorm_o,
    output logic                                out_last_o,
    output logic [$clog2(DEPTH):0]              count_o,
    output logic                                overflow_o,
    output logic                                done_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    cc_state_t                             state_q, state_d;
    logic [CW-1:0]                         count, n_push;
    logic [PARALLEL_SIZE-1:0][2*WIDTH-1:0] wdata;
    logic [2*WIDTH-1:0]                    head;
    logic                                  pop, drop, clr, overflow_q;
    int                                    free_slots;
`ifdef CENTER_COLLECT_DEDUP_EN
    logic [WIDTH-1:0]                      last_id_q, last_id_d;
    logic                                  last_vld_q;
    logic [PARALLEL_SIZE-1:0]              stored;
`endif

    assign clr        = state_q == DONE && stage_i == 3'd0;
    assign free_slots = DEPTH - int'(count) + int'(pop);

    // State register.
    always_ff @(posedge CLK_i or negedge RST_ni)
        if (!RST_ni) state_q <= IDLE;
        else         state_q <= state_d;

    // Next state: drain ends on the last handshake, or at once when nothing is buffered.
    always_comb
        state_d = (state_q == IDLE    && stage_i == 3'd6)                          ? COLLECT :
                  (state_q == COLLECT && finished_i)                               ? DRAIN   :
                  (state_q == DRAIN   && (count == '0 || (out_last_o && out_ready_i))) ? DONE    :
                  clr                                                              ? IDLE    : state_q;

    // FSM outputs: the head is only offered while collecting or draining.
    always_comb begin
        out_valid_o = (state_q == COLLECT || state_q == DRAIN) && count != '0;
        out_last_o  = state_q == DRAIN && count == CW'(1);
        done_o      = state_q == DONE;
        pop         = out_valid_o && out_ready_i;
    end

    // Pack surviving lanes in ascending order into the free slots; lanes beyond them are dropped.
    always_comb begin
        int   n;
        logic keep;
        n     = 0;
        keep  = 1'b0;
        drop  = 1'b0;
        wdata = '0;
`ifdef CENTER_COLLECT_DEDUP_EN
        stored    = '0;
        last_id_d = last_id_q;
`endif
        for (int k = 0; k < PARALLEL_SIZE; k++) begin
            keep = state_q == COLLECT && id_i[k] != WIDTH'(N_INVALID);
`ifdef CENTER_COLLECT_DEDUP_EN
            keep = keep && !(last_vld_q && id_i[k] == last_id_q);
            for (int j = 0; j < k; j++)
                keep = keep && !(stored[j] && id_i[j] == id_i[k]);
`endif
            if (keep && n < free_slots) begin
                for (int s = 0; s < PARALLEL_SIZE; s++)
                    if (s == n) wdata[s] = {id_i[k], dnorm_i[k]};
`ifdef CENTER_COLLECT_DEDUP_EN
                stored[k] = 1'b1;
                last_id_d = id_i[k];
`endif
                n++;
            end else if (keep) begin
                drop = 1'b1;
            end
        end
        n_push = CW'(n);
    end

    // Sticky overflow, cleared when the run is handed back to idle.
    always_ff @(posedge CLK_i or negedge RST_ni)
        if (!RST_ni) overflow_q <= 1'b0;
        else         overflow_q <= clr ? 1'b0 : overflow_q | drop;

`ifdef CENTER_COLLECT_DEDUP_EN
    // Last stored id, forgotten while idle so each run starts fresh.
    always_ff @(posedge CLK_i or negedge RST_ni)
        if (!RST_ni) begin
            last_id_q  <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_id_q  <= state_q == IDLE ? '0 : last_id_d;
            last_vld_q <= state_q == IDLE ? 1'b0 : last_vld_q | (|stored);
        end
`endif

    mw_fifo #(
        .DW    (2*WIDTH),
        .LANES (PARALLEL_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK_i     (CLK_i),
        .RST_ni    (RST_ni),
        .clr_i     (clr),
        .wr_num_i  (n_push),
        .wr_data_i (wdata),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .count_o   (count)
    );

    assign count_o     = count;
    assign stall_o     = DEPTH - int'(count) < PARALLEL_SIZE;
    assign overflow_o  = overflow_q;
    assign out_id_o    = out_valid_o ? head[2*WIDTH-1:WIDTH] : '0;
    assign out_dnorm_o = out_valid_o ? head[WIDTH-1:0] : '0;

endmodule

// File: tb/tb_center_collect.sv
// tb_center_collect: directed self-checking bench for center_collect
module tb_center_collect;
    import dal_pkg::*;

    localparam int W  = 16;
    localparam int P  = 2;
    localparam int D  = 16;
    localparam logic [15:0] NI = 16'd4096;

    logic                CLK_i = 1'b0;
    logic                RST_ni = 1'b0;
    logic [2:0]          stage_i = 3'd0;
    logic                finished_i = 1'b0;
    logic [P-1:0][W-1:0] id_i;
    logic [P-1:0][W-1:0] dnorm_i;
    logic                stall_o, out_valid_o, out_last_o, overflow_o, done_o;
    logic                out_ready_i = 1'b0;
    logic [W-1:0]        out_id_o, out_dnorm_o;
    logic [4:0]          count_o;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] q[$];

    center_collect #(.WIDTH(W), .PARALLEL_SIZE(P), .N_INVALID(4096), .DEPTH(D)) dut (
        .CLK_i       (CLK_i),
        .RST_ni      (RST_ni),
        .stage_i     (stage_i),
        .finished_i  (finished_i),
        .id_i        (id_i),
        .dnorm_i     (dnorm_i),
        .stall_o     (stall_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_id_o    (out_id_o),
        .out_dnorm_o (out_dnorm_o),
        .out_last_o  (out_last_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .done_o      (done_o)
    );

    always #5 CLK_i = ~CLK_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK_i);
        #1;
    endtask

    task automatic lanes(input logic [15:0] a, input logic [15:0] b);
        id_i[0]    = a;
        id_i[1]    = b;
        dnorm_i[0] = a ^ 16'h5a5a;
        dnorm_i[1] = b ^ 16'h5a5a;
    endtask

    task automatic drain(input string tag, input logic [15:0] exp[$]);
        out_ready_i = 1'b1;
        foreach (exp[i]) begin
            check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
            check({tag, "_id"}, 32'(out_id_o), 32'(exp[i]));
            check({tag, "_dnorm"}, 32'(out_dnorm_o), 32'(exp[i] ^ 16'h5a5a));
            check({tag, "_last"}, 32'(out_last_o), 32'(i == exp.size() - 1));
            tick;
        end
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_state"}, 32'(dut.state_q), 32'(DONE));
        out_ready_i = 1'b0;
    endtask

    initial begin
        lanes(NI, NI);
        #12;
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_id", 32'(out_id_o), 32'd0);
        RST_ni  = 1'b1;

        // basic flow with an invalid lane and last marker
        stage_i = 3'd6;
        tick;
        check("basic_collect", 32'(dut.state_q), 32'(COLLECT));
        lanes(16'd3, NI);
        out_ready_i = 1'b1;
        tick;
        check("basic_id3", 32'(out_id_o), 32'd3);
        check("basic_dn3", 32'(out_dnorm_o), 32'h5a59);
        check("basic_cnt1", 32'(count_o), 32'd1);
        check("basic_nolast", 32'(out_last_o), 32'd0);
        lanes(16'd7, 16'd9);
        tick;
        check("basic_id7", 32'(out_id_o), 32'd7);
        check("basic_cnt2", 32'(count_o), 32'd2);
        lanes(NI, NI);
        finished_i = 1'b1;
        tick;
        finished_i = 1'b0;
        check("basic_drain", 32'(dut.state_q), 32'(DRAIN));
        check("basic_id9", 32'(out_id_o), 32'd9);
        check("basic_last", 32'(out_last_o), 32'd1);
        tick;
        check("basic_done", 32'(done_o), 32'd1);
        check("basic_valid0", 32'(out_valid_o), 32'd0);
        stage_i = 3'd0;
        tick;
        check("basic_idle", 32'(dut.state_q), 32'(IDLE));
        check("basic_done0", 32'(done_o), 32'd0);

        // backpressure fill to full
        out_ready_i = 1'b0;
        stage_i = 3'd6;
        tick;
        stage_i = 3'd0;
        for (int i = 0; i < 8; i++) begin
            lanes(16'd1, 16'd2);
            tick;
            check("bp_count", 32'(count_o), 32'(2 * (i + 1)));
            check("bp_stall", 32'(stall_o), 32'((16 - 2 * (i + 1)) < 2));
        end
        check("bp_head", 32'(out_id_o), 32'd1);
        check("bp_ovf", 32'(overflow_o), 32'd0);

        // push into a full FIFO while popping
        lanes(16'd10, NI);
        out_ready_i = 1'b1;
        tick;
        check("sim_count", 32'(count_o), 32'd16);
        check("sim_head", 32'(out_id_o), 32'd2);
        check("sim_ovf", 32'(overflow_o), 32'd0);
        lanes(NI, NI);
        tick;
        check("pop_count", 32'(count_o), 32'd15);
        check("stall15", 32'(stall_o), 32'd1);
        check("pop_head", 32'(out_id_o), 32'd1);

        // overflow at count 15
        out_ready_i = 1'b0;
        lanes(16'd5, 16'd6);
        tick;
        check("ovf_count", 32'(count_o), 32'd16);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        lanes(NI, NI);
        tick;
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        finished_i = 1'b1;
        tick;
        finished_i = 1'b0;
        check("hold_head", 32'(out_id_o), 32'd1);
        check("hold_count", 32'(count_o), 32'd16);
        q = {};
        for (int i = 0; i < 7; i++) begin
            q.push_back(16'd1);
            q.push_back(16'd2);
        end
        q.push_back(16'd10);
        q.push_back(16'd5);
        drain("order", q);
        check("done_ovf", 32'(overflow_o), 32'd1);
        stage_i = 3'd0;
        tick;
        check("idle_ovf_clr", 32'(overflow_o), 32'd0);
        check("idle_count", 32'(count_o), 32'd0);

        // duplicate ids
        stage_i = 3'd6;
        tick;
        stage_i = 3'd0;
        lanes(16'd8, 16'd8);
        tick;
        lanes(16'd8, 16'd2);
        tick;
        lanes(NI, NI);
        finished_i = 1'b1;
        tick;
        finished_i = 1'b0;
`ifdef CENTER_COLLECT_DEDUP_EN
        q = '{16'd8, 16'd2};
`else
        q = '{16'd8, 16'd8, 16'd8, 16'd2};
`endif
        check("dup_count", 32'(count_o), 32'(q.size()));
        drain("dup", q);
        tick;

        // reset in the middle of draining
        stage_i = 3'd6;
        tick;
        stage_i = 3'd0;
        lanes(16'd1, 16'd2);
        tick;
        lanes(16'd3, 16'd4);
        tick;
        lanes(NI, NI);
        finished_i = 1'b1;
        tick;
        finished_i = 1'b0;
        check("mid_state", 32'(dut.state_q), 32'(DRAIN));
        check("mid_count", 32'(count_o), 32'd4);
        #2 RST_ni = 1'b0;
        #1;
        check("ar_count", 32'(count_o), 32'd0);
        check("ar_valid", 32'(out_valid_o), 32'd0);
        check("ar_state", 32'(dut.state_q), 32'(IDLE));
        check("ar_id", 32'(out_id_o), 32'd0);
        #2 RST_ni = 1'b1;
        tick;
        check("post_count", 32'(count_o), 32'd0);
        check("post_state", 32'(dut.state_q), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/center_collect.md
CENTER_COLLECT -- requirements
Module: center_collect

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter PARALLEL_SIZE, default 2, lanes per cycle.
REQ-003 SHALL have parameter N_INVALID, default 4096, the "no centre" id.
REQ-004 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, at least 2*PARALLEL_SIZE).
REQ-005 SHALL have the following ports; one clock; reset is asynchronous and active-low.
- CLK_i, input, 1: clock, rising edge.
- RST_ni, input, 1: asynchronous active-low reset.
- stage_i, input, 3: stage index from the upstream pipe stage.
- finished_i, input, 1: upstream run complete (stage 7).
- id_i, input, [PARALLEL_SIZE][WIDTH]: per-lane centre id.
- dnorm_i, input, [PARALLEL_SIZE][WIDTH]: per-lane fp16 dnorm.
- stall_o, output, 1: free slots are fewer than PARALLEL_SIZE.
- out_valid_o, output, 1: an output entry is valid.
- out_ready_i, input, 1: downstream accepts the entry.
- out_id_o, output, WIDTH: head id.
- out_dnorm_o, output, WIDTH: head dnorm.
- out_last_o, output, 1: final entry of the run.
- count_o, output, $clog2(DEPTH)+1: FIFO occupancy.
- overflow_o, output, 1: sticky flag, an entry was dropped.
- done_o, output, 1: run fully drained.

Function
REQ-006 SHALL implement FSM IDLE, COLLECT, DRAIN, DONE.
- IDLE->COLLECT when stage_i==6.
- COLLECT->DRAIN when finished_i==1.
- DRAIN->DONE on the handshake of the out_last_o entry, or immediately if the FIFO is empty.
- DONE->IDLE when stage_i==0.
REQ-007 SHALL, in COLLECT only, treat lane k as valid when id_i[k]!=N_INVALID; invalid lanes are never stored.
REQ-008 SHALL push valid lanes in the same cycle, ascending lane order, contiguously packed; write-to-visible latency is 1 cycle.
REQ-009 SHALL drive stall_o combinationally as (DEPTH-count) < PARALLEL_SIZE; it is advisory only.
REQ-010 SHALL, when valid lanes exceed free slots, store the lowest-index lanes that fit, drop the rest, and set overflow_o.
REQ-011 SHALL drive out_valid_o = count!=0 in COLLECT and DRAIN, and 0 in IDLE and DONE; pop occurs on out_valid_o&&out_ready_i.
REQ-012 SHALL hold head data stable while out_valid_o&&!out_ready_i.
REQ-013 SHALL, on a simultaneous push and pop, update count as count+pushes-1 and allow a full FIFO to accept one push in that cycle.
REQ-014 SHALL assert out_last_o only in DRAIN with count==1, alongside out_valid_o.
REQ-015 SHALL wrap read and write pointers modulo DEPTH.
REQ-016 SHALL hold done_o=1 throughout DONE.
REQ-017 SHALL, on the DONE->IDLE transition, clear overflow_o and leave the FIFO empty.
REQ-018 SHALL ignore finished_i outside COLLECT, and ignore id_i/dnorm_i outside COLLECT.

Reset
REQ-019 SHALL, on RST_ni low at any time (including mid-run), asynchronously enter IDLE, empty the FIFO, and clear the pointers.
REQ-020 SHALL hold all outputs at 0 during reset except stall_o, which is 0 because count is 0.

Configuration
REQ-021 SHALL support macro CENTER_COLLECT_DEDUP_EN.
- Defined: a valid lane whose id equals the last pushed id, or an earlier lane pushed in the same cycle, is discarded without setting overflow; the last-pushed id register clears in IDLE.
- Undefined: all valid lanes are pushed and no dedup logic exists.

Structure
REQ-022 SHALL take the state enum, N_INVALID and the default WIDTH from shared package dal_pkg.
REQ-023 SHALL place storage in sub-module mw_fifo: a multi-write, single-read synchronous FIFO with count output.

Verification
REQ-024 Basic: stage 6, ids {3,4096} then {7,9}, out_ready_i=1, then finished_i -> outputs (3), (7), (9); out_last_o on 9; done_o next cycle.
REQ-025 Backpressure: out_ready_i=0 and 8 cycles of {1,2} with DEPTH=16 -> count 16; stall_o at count 15; no overflow; head stays id 1.
REQ-026 Overflow: count=15 and both lanes valid {5,6} -> 5 stored, 6 dropped, overflow_o=1 until the next IDLE.
REQ-027 Simultaneous: full FIFO, out_ready_i=1, one valid lane -> count stays 16, order preserved.
REQ-028 Reset: RST_ni low mid-DRAIN with count=4 -> count_o=0, out_valid_o=0, state IDLE.
REQ-029 Dedup (macro defined): ids {8,8} then {8,2} -> outputs 8, 2 only; with the macro undefined -> 8, 8, 8, 2.
